// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the mem_bank_rsync register/memory bank.
// Holds the controller state enum and the byte-enable merge used by both the
// write path and the read-port bypass path.
package mem_bank_pkg;

    localparam int ByteWidth    = 8;
    // be_merge works on this fixed width; callers size-cast in and out, so any
    // DataWidth up to this value (and a multiple of 8) is supported.
    localparam int MaxDataWidth = 256;
    localparam int MaxBytes     = MaxDataWidth / ByteWidth;

    typedef enum logic {
        CLEAR,
        READY
    } mem_bank_state_e;

    // Replace the bytes of old_word selected by be with the bytes of new_word.
    function automatic logic [MaxDataWidth-1:0] be_merge(
        input logic [MaxDataWidth-1:0] old_word,
        input logic [MaxDataWidth-1:0] new_word,
        input logic [MaxBytes-1:0]     be
    );
        logic [MaxDataWidth-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MaxBytes; k++) begin
            if (be[k]) begin
                merged[k*ByteWidth +: ByteWidth] = new_word[k*ByteWidth +: ByteWidth];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_bank_rd_port.sv
// One registered read port of mem_bank_rsync.
// Applies the address range check (out-of-range reads return zero) and, when
// the build defines MEM_BANK_BYPASS_EN, forwards a same-edge write to the
// read data; otherwise a colliding read returns the old word.
module mem_bank_rd_port
    import mem_bank_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int NumEntries = 32,
    parameter int AddrWidth  = $clog2(NumEntries),
    parameter int NumBytes   = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 en_i,
    input  logic [DataWidth-1:0] mem_i [NumEntries],
    input  logic                 rd_valid_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic [NumBytes-1:0]  wr_be_i,
    output logic [DataWidth-1:0] rd_data_o,
    output logic                 rd_valid_o
);

    logic                 addr_in_range;
    logic [DataWidth-1:0] rd_word_d;
    logic [DataWidth-1:0] rd_data_q;
    logic                 rd_valid_q;

    // Pick the word to capture: stored word, forwarded write, or zero.
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_word_d     = '0;
        addr_in_range = int'(rd_addr_i) < NumEntries;
        if (addr_in_range) begin
            rd_word_d = mem_i[rd_addr_i];
`ifdef MEM_BANK_BYPASS_EN
            if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_word_d = DataWidth'(be_merge(MaxDataWidth'(mem_i[rd_addr_i]),
                                                MaxDataWidth'(wr_data_i),
                                                MaxBytes'(wr_be_i)));
            end
`endif
        end
    end

`ifndef MEM_BANK_BYPASS_EN
    // Write-side inputs only feed the bypass mux.
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i, wr_be_i};
`endif

    // Register read data and valid; data holds when there is no request.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (en_i && rd_valid_i) begin
            rd_data_q  <= rd_word_d;
            rd_valid_q <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/mem_bank_rsync.sv
// mem_bank_rsync: synchronous-read memory bank with NumReadPorts registered
// read ports, byte-enable writes and a hardware clear sequence after reset.
// Build option: define MEM_BANK_BYPASS_EN to make a same-address read and
// write at one edge return the new (merged) word instead of the old one.
// DataWidth must be a multiple of 8 and no wider than MaxDataWidth.
module mem_bank_rsync
    import mem_bank_pkg::*;
#(
    parameter  int DataWidth    = 32,
    parameter  int NumEntries   = 32,
    parameter  int NumReadPorts = 2,
    localparam int AddrWidth    = $clog2(NumEntries),
    localparam int NumBytes     = DataWidth / 8
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    output logic                    init_busy_o,
    input  logic                    wr_valid_i,
    input  logic [NumBytes-1:0]     wr_be_i,
    input  logic [AddrWidth-1:0]    wr_addr_i,
    input  logic [DataWidth-1:0]    wr_data_i,
    input  logic [NumReadPorts-1:0] rd_valid_i,
    input  logic [AddrWidth-1:0]    rd_addr_i [NumReadPorts],
    output logic [DataWidth-1:0]    rd_data_o [NumReadPorts],
    output logic [NumReadPorts-1:0] rd_valid_o
);

    localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumEntries - 1);

    mem_bank_state_e      state_q;
    logic [AddrWidth-1:0] clear_idx_q;
    logic                 init_busy_q;
    logic [DataWidth-1:0] mem_q [NumEntries];

    logic                 ready;
    logic                 wr_en;
    logic [DataWidth-1:0] wr_word_d;

    assign ready = (state_q == READY);
    // Out-of-range writes are dropped; everything is ignored while clearing.
    assign wr_en = ready && wr_valid_i && (int'(wr_addr_i) < NumEntries);
    assign wr_word_d = DataWidth'(be_merge(MaxDataWidth'(mem_q[wr_addr_i]),
                                           MaxDataWidth'(wr_data_i),
                                           MaxBytes'(wr_be_i)));

    // Controller: walk the clear index once after reset, then stay READY.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= CLEAR;
            clear_idx_q <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clear_idx_q == LastIdx) begin
                        state_q     <= READY;
                        init_busy_q <= 1'b0;
                    end else begin
                        clear_idx_q <= clear_idx_q + AddrWidth'(1);
                    end
                end
                READY: begin
                    state_q <= READY;
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign init_busy_o = init_busy_q;

    // Storage: zero one entry per cycle while clearing, else apply writes.
    // NOTE: the array has no reset branch; the CLEAR walk zeroes it, which keeps it mappable to RAM.
    always_ff @(posedge clk_i) begin
        if (reset_ni) begin
            if (state_q == CLEAR) begin
                mem_q[clear_idx_q] <= '0;
            end else if (wr_en) begin
                mem_q[wr_addr_i] <= wr_word_d;
            end
        end
    end

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd_port
        mem_bank_rd_port #(
            .DataWidth  (DataWidth),
            .NumEntries (NumEntries),
            .AddrWidth  (AddrWidth),
            .NumBytes   (NumBytes)
        ) u_rd_port (
            .clk_i      (clk_i),
            .reset_ni   (reset_ni),
            .en_i       (ready),
            .mem_i      (mem_q),
            .rd_valid_i (rd_valid_i[p]),
            .rd_addr_i  (rd_addr_i[p]),
            .wr_en_i    (wr_en),
            .wr_addr_i  (wr_addr_i),
            .wr_data_i  (wr_data_i),
            .wr_be_i    (wr_be_i),
            .rd_data_o  (rd_data_o[p]),
            .rd_valid_o (rd_valid_o[p])
        );
    end

endmodule

// File: tb/tb_mem_bank_rsync.sv
// Testbench for mem_bank_rsync. Two instances share one stimulus stream:
// NumEntries=32 (dut_a) and NumEntries=20 (dut_b, exercises out-of-range).
// A behavioural model predicts each edge; predictions are queued and compared
// after the edge, alongside directed constant checks.
module tb_mem_bank_rsync;

    localparam int DW      = 32;
    localparam int NP      = 2;
    localparam int AW      = 5;
    localparam int NumDuts = 2;

`ifdef MEM_BANK_BYPASS_EN
    localparam bit          Bypass  = 1'b1;
    localparam logic [31:0] ExpColl = 32'hFFFF_FFFF;
`else
    localparam bit          Bypass  = 1'b0;
    localparam logic [31:0] ExpColl = 32'h0000_0001;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_valid;
    logic [3:0]    wr_be;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NP-1:0] rd_valid;
    logic [AW-1:0] rd_addr [NP];

    logic          busy_a, busy_b;
    logic [DW-1:0] rd_data_a [NP];
    logic [DW-1:0] rd_data_b [NP];
    logic [NP-1:0] rd_valid_a, rd_valid_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_bank_rsync #(.DataWidth(DW), .NumEntries(32), .NumReadPorts(NP)) dut_a (
        .clk_i(clk), .reset_ni(reset_n), .init_busy_o(busy_a),
        .wr_valid_i(wr_valid), .wr_be_i(wr_be), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a)
    );

    mem_bank_rsync #(.DataWidth(DW), .NumEntries(20), .NumReadPorts(NP)) dut_b (
        .clk_i(clk), .reset_ni(reset_n), .init_busy_o(busy_b),
        .wr_valid_i(wr_valid), .wr_be_i(wr_be), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b)
    );

    // ---------------- model and scoreboard ----------------
    typedef struct {
        int            dut;
        logic          busy;
        logic [NP-1:0] vld;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } exp_t;

    exp_t          sb_q [$];
    logic [DW-1:0] m_mem [NumDuts][32];
    logic          m_busy [NumDuts];
    int            m_idx [NumDuts];
    logic [DW-1:0] m_rdd [NumDuts][NP];
    logic [NP-1:0] m_rdv [NumDuts];

    function automatic int entries_of(input int d);
        return (d == 0) ? 32 : 20;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = n[k*8 +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Predict the outputs after the coming edge from the current inputs.
    task automatic predict();
        for (int d = 0; d < NumDuts; d++) begin
            int   n;
            exp_t e;
            n = entries_of(d);
            if (!reset_n) begin
                m_busy[d] = 1'b1;
                m_idx[d]  = 0;
                m_rdv[d]  = '0;
                for (int p = 0; p < NP; p++) m_rdd[d][p] = '0;
            end else if (m_busy[d]) begin
                m_mem[d][m_idx[d]] = '0;
                if (m_idx[d] == n - 1) m_busy[d] = 1'b0;
                else m_idx[d]++;
                m_rdv[d] = '0;
            end else begin
                for (int p = 0; p < NP; p++) begin
                    m_rdv[d][p] = rd_valid[p];
                    if (rd_valid[p]) begin
                        if (int'(rd_addr[p]) >= n) m_rdd[d][p] = '0;
                        else if (Bypass && wr_valid && wr_addr == rd_addr[p])
                            m_rdd[d][p] = merge(m_mem[d][rd_addr[p]], wr_data, wr_be);
                        else m_rdd[d][p] = m_mem[d][rd_addr[p]];
                    end
                end
                if (wr_valid && int'(wr_addr) < n)
                    m_mem[d][wr_addr] = merge(m_mem[d][wr_addr], wr_data, wr_be);
            end
            e.dut  = d;
            e.busy = m_busy[d];
            e.vld  = m_rdv[d];
            e.d0   = m_rdd[d][0];
            e.d1   = m_rdd[d][1];
            sb_q.push_back(e);
        end
    endtask

    // One clock: queue predictions, clock the DUTs, compare on the falling edge.
    task automatic step();
        predict();
        @(posedge clk);
        @(negedge clk);
        while (sb_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = sb_q.pop_front();
            nm = (e.dut == 0) ? "a" : "b";
            check({"sb busy ", nm}, DW'(e.dut == 0 ? busy_a : busy_b), DW'(e.busy));
            check({"sb rd_valid ", nm}, DW'(e.dut == 0 ? rd_valid_a : rd_valid_b), DW'(e.vld));
            check({"sb rd_data0 ", nm}, e.dut == 0 ? rd_data_a[0] : rd_data_b[0], e.d0);
            check({"sb rd_data1 ", nm}, e.dut == 0 ? rd_data_a[1] : rd_data_b[1], e.d1);
        end
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        rd_valid = '0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] dat, input logic [3:0] be);
        idle();
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = dat;
        wr_be    = be;
        step();
    endtask

    task automatic read2(input logic [NP-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        idle();
        rd_valid   = v;
        rd_addr[0] = a0;
        rd_addr[1] = a1;
        step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int fall_a;
        int fall_b;

        reset_n    = 1'b0;
        idle();
        wr_be      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_addr[0] = '0;
        rd_addr[1] = '0;
        step();
        step();
        check("reset busy_a", DW'(busy_a), DW'(1));
        check("reset rd_valid_a", DW'(rd_valid_a), DW'(0));
        check("reset rd_data_a0", rd_data_a[0], 32'h0);

        // Release, issue requests during clear, then reset at clear cycle 10.
        reset_n    = 1'b1;
        wr_valid   = 1'b1;
        wr_be      = 4'hF;
        wr_addr    = 5'd3;
        wr_data    = 32'hBAD0_BAD0;
        rd_valid   = 2'b11;
        rd_addr[0] = 5'd3;
        rd_addr[1] = 5'd5;
        for (int i = 0; i < 10; i++) step();
        check("clear rd_valid_a ignored", DW'(rd_valid_a), DW'(0));
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        fall_a  = 0;
        fall_b  = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 15) idle();
            step();
            if (!busy_a && fall_a == 0) fall_a = i;
            if (!busy_b && fall_b == 0) fall_b = i;
        end
        check("busy_a falls after edge", DW'(fall_a), DW'(32));
        check("busy_b falls after edge", DW'(fall_b), DW'(20));

        // Cleared contents; address 3 must not hold the clear-time write.
        read2(2'b11, 5'd0, 5'd17);
        check("clear rd 0", rd_data_a[0], 32'h0);
        check("clear rd 17", rd_data_a[1], 32'h0);
        check("clear rd valid", DW'(rd_valid_a), DW'(2'b11));
        read2(2'b11, 5'd31, 5'd3);
        check("clear rd 31", rd_data_a[0], 32'h0);
        check("clear rd 3 no write", rd_data_a[1], 32'h0);

        // Byte enables.
        write(5'd5, 32'hAABB_CCDD, 4'hF);
        write(5'd5, 32'h1122_3344, 4'h5);
        read2(2'b01, 5'd5, 5'd0);
        check("be merge a", rd_data_a[0], 32'hAA22_CC44);
        check("be merge b", rd_data_b[0], 32'hAA22_CC44);

        // Multi-port reads, then hold.
        write(5'd3, 32'hDEAD_BEEF, 4'hF);
        write(5'd9, 32'h1234_5678, 4'hF);
        read2(2'b11, 5'd3, 5'd9);
        check("mp port0", rd_data_a[0], 32'hDEAD_BEEF);
        check("mp port1", rd_data_a[1], 32'h1234_5678);
        check("mp valid", DW'(rd_valid_a), DW'(2'b11));
        idle();
        step();
        check("mp idle valid", DW'(rd_valid_a), DW'(0));
        check("mp hold port0", rd_data_a[0], 32'hDEAD_BEEF);
        check("mp hold port1", rd_data_a[1], 32'h1234_5678);

        // Same address on both ports.
        read2(2'b11, 5'd9, 5'd9);
        check("same addr p0", rd_data_a[0], 32'h1234_5678);
        check("same addr p1", rd_data_a[1], 32'h1234_5678);

        // Read-during-write collision.
        write(5'd7, 32'h0000_0001, 4'hF);
        wr_valid   = 1'b1;
        wr_addr    = 5'd7;
        wr_data    = 32'hFFFF_FFFF;
        wr_be      = 4'hF;
        rd_valid   = 2'b01;
        rd_addr[0] = 5'd7;
        step();
        check("collision", rd_data_a[0], ExpColl);
        read2(2'b01, 5'd7, 5'd0);
        check("after collision", rd_data_a[0], 32'hFFFF_FFFF);

        // Zero byte enable is a no-op.
        write(5'd9, 32'h0, 4'h0);
        read2(2'b01, 5'd9, 5'd0);
        check("be zero no-op", rd_data_a[0], 32'h1234_5678);

        // Out-of-range on the 20-entry instance.
        write(5'd25, 32'hCAFE_F00D, 4'hF);
        read2(2'b11, 5'd25, 5'd5);
        check("oor rd 25 b", rd_data_b[0], 32'h0);
        check("oor valid b", DW'(rd_valid_b), DW'(2'b11));
        check("oor alias 5 b", rd_data_b[1], 32'hAA22_CC44);
        check("in range 25 a", rd_data_a[0], 32'hCAFE_F00D);

        // Reset mid-operation clears the contents again.
        idle();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) step();
        read2(2'b11, 5'd5, 5'd3);
        check("rereset rd 5", rd_data_a[0], 32'h0);
        check("rereset rd 3", rd_data_a[1], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bank_rsync.md
# mem_bank_rsync

Parametrised synchronous-read register/memory bank with multiple independent read ports, byte-enable writes and a hardware clear sequence after reset. It replaces the single-port memory in the pipeline's register-file and scratch-memory slots. Every read port returns data one cycle after the request, together with a valid flag, and the contents are guaranteed zero after reset without any init file.

## Interface
- `DataWidth`, default 32: word width in bits; must be a multiple of 8.
- `NumEntries`, default 32: number of words; ≥ 2, need not be a power of two.
- `NumReadPorts`, default 2: number of independent read ports; ≥ 1.
- `AddrWidth` (localparam) = `$clog2(NumEntries)`.
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `reset_ni`  in  1  synchronous, active-low reset.
- `init_busy_o`  out  1  high while the clear sequence runs.
- `wr_valid_i`  in  1  write request.
- `wr_be_i`  in  DataWidth/8  byte enables; bit k selects byte k.
- `wr_addr_i`  in  AddrWidth  write address.
- `wr_data_i`  in  DataWidth  write data.
- `rd_valid_i`  in  [NumReadPorts]  per-port read request.
- `rd_addr_i`  in  [NumReadPorts][AddrWidth]  per-port read address.
- `rd_data_o`  out  [NumReadPorts][DataWidth]  registered read data.
- `rd_valid_o`  out  [NumReadPorts]  rd_data_o updated this cycle.

## Operation
- Two-state FSM, CLEAR and READY.
- Reset (`reset_ni`=0 at a rising edge): state ← CLEAR, clear index ← 0, all `rd_data_o` ← 0, all `rd_valid_o` ← 0.
- CLEAR: each cycle writes 0 to `mem[clear_idx]` and increments the index. At index NumEntries-1 the last entry is written and the FSM moves to READY on the same edge. `init_busy_o` = 1 in CLEAR, 0 in READY.
- In CLEAR, `wr_valid_i` and `rd_valid_i` are ignored: no write, `rd_valid_o` = 0. Requesters hold off while `init_busy_o` is high. No requests are queued.
- READY write: bytes with `wr_be_i[k]`=1 are replaced and all other bytes are kept. `wr_be_i`=0 with `wr_valid_i`=1 is a legal no-op.
- READY read, port p: `rd_valid_i[p]` sampled at edge N gives `rd_data_o[p]` = word and `rd_valid_o[p]` = 1 after edge N. Without a request, `rd_valid_o[p]` = 0 and `rd_data_o[p]` holds its previous value.
- Any number of ports may read the same address in the same cycle; each port gets identical data.
- Read-during-write to the same address: behaviour is set by `MEM_BANK_BYPASS_EN`, see Configuration.
- Out-of-range address (≥ NumEntries):
  - Write is dropped.
  - Read returns 0 with `rd_valid_o` = 1.
- Reset asserted mid-clear or mid-operation: the sequence restarts from index 0 and earlier contents are lost.

## Timing
- Read latency is exactly 1 cycle with full throughput: one read per port per cycle.
- A write at edge N is visible to reads sampled at edge N+1 or later.
- Clear takes NumEntries cycles after reset deasserts. `init_busy_o` falls after the NumEntries-th rising edge with `reset_ni`=1.
- No combinational path from inputs to outputs.

## Configuration
- `MEM_BANK_BYPASS_EN` defined: a read and a write to the same address at the same edge return the new word. This is the old word merged with `wr_data_i` under `wr_be_i`.
- `MEM_BANK_BYPASS_EN` undefined: the same collision returns the old word (read-before-write).
- Clear-phase behaviour is identical in both builds.

## Structure
- Package `mem_bank_pkg` holds:
  - State enum `mem_bank_state_e` {CLEAR, READY}.
  - Function `be_merge(old, new, be)` used for both the write path and the bypass path.
- Sub-module `mem_bank_rd_port`, instantiated NumReadPorts times by a generate loop. Each instance registers data and valid, applies the range check, and applies the bypass mux.
- Storage array, FSM and clear counter live in the top module.

## Test plan
- Clear: NumEntries=32. Release reset. `init_busy_o` is high for exactly 32 cycles, then low. Reads of addresses 0, 17 and 31 return 0x0000_0000 with `rd_valid_o`=1.
- Byte enables: write 0xAABBCCDD to address 5 with be=0xF, then 0x11223344 with be=0x5. A read of address 5 returns 0xAA22CC44.
- Multi-port: write 0xDEADBEEF to address 3 and 0x12345678 to address 9. Port 0 reads 3 and port 1 reads 9 in the same cycle. Next cycle: 0xDEADBEEF / 0x12345678, both valid. With no further requests, both `rd_valid_o` drop to 0 and the data holds.
- Collision: address 7 holds 0x0000_0001. Write 0xFFFF_FFFF to address 7 and read address 7 at the same edge. Returns 0xFFFF_FFFF with `MEM_BANK_BYPASS_EN`, 0x0000_0001 without it.
- Reset mid-clear: assert `reset_ni`=0 at clear cycle 10 for one cycle. `init_busy_o` then stays high for a full 32 further cycles. Requests issued during clear produce no write and `rd_valid_o`=0.
- Out-of-range: NumEntries=20. A write to address 25 is dropped. A read of address 25 returns 0 with valid=1, and address 5 (25 mod 20) is unchanged.
